// File: rtl/note_sequencer.sv
// note_sequencer: picks one of eight notes (C5..C6) for the downstream clock
// divider, either from switches or by stepping at a fixed rate, and drives the
// divider's terminal count and reset so every tone starts at a clean phase.
module note_sequencer #(
  parameter int unsigned CLK_HZ     = 50000000,  // clock the note table is derived from
  parameter int unsigned STEP_TICKS = 25000000   // cycles per note in auto mode, >= 2
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        auto_mode,
  input  logic        direction,
  input  logic [2:0]  note_sel,
  output logic [31:0] count_end,
  output logic        divider_reset,
  output logic [2:0]  note_index,
  output logic        step_pulse,
  output logic        playing
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY_MAN  = 2'd1,
    PLAY_AUTO = 2'd2
  } state_t;

  // Half-period terminal counts, CLK_HZ / (2 * f) with f in whole hertz:
  // C5 523, D5 587, E5 659, F5 698, G5 783, A5 880, B5 987, C6 1046.
  // At 50 MHz: 47801 42589 37936 35816 31928 28409 25329 23900.
  localparam logic [31:0] NOTE_TABLE [8] = '{
    CLK_HZ / 1046, CLK_HZ / 1174, CLK_HZ / 1318, CLK_HZ / 1396,
    CLK_HZ / 1566, CLK_HZ / 1760, CLK_HZ / 1974, CLK_HZ / 2092
  };

  localparam logic [31:0] TICK_LAST = 32'(STEP_TICKS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_tick;
  logic [31:0] w_tick_next;
  logic [2:0]  r_note;
  logic [2:0]  w_note_next;
  logic [31:0] r_count_end;
  logic        r_div_rst;
  logic        w_div_rst_next;
  logic        r_step;
  logic        w_step_next;
  logic        r_playing;
  logic        w_terminal;

  assign w_terminal = (r_tick == TICK_LAST);

  // Next state, next note, tick counter and divider control for the coming edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_state_next   = r_state;
    w_tick_next    = r_tick;
    w_note_next    = r_note;
    w_div_rst_next = 1'b0;
    w_step_next    = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Preload the first note while muted.
        w_note_next    = note_sel;
        w_tick_next    = '0;
        w_div_rst_next = 1'b1;
        if (start && !stop) begin
          w_state_next   = auto_mode ? PLAY_AUTO : PLAY_MAN;
          w_div_rst_next = 1'b0;
        end
      end

      PLAY_MAN: begin
        w_tick_next = '0;
        if (stop) begin
          w_state_next   = IDLE;
          w_div_rst_next = 1'b1;
        end else if (auto_mode) begin
          // PLAY_MAN is only entered with auto_mode low, so a high level here
          // is the rising edge; keep the current note and count from zero.
          w_state_next = PLAY_AUTO;
        end else if (note_sel != r_note) begin
          w_note_next    = note_sel;
          w_div_rst_next = 1'b1;
        end
      end

      PLAY_AUTO: begin
        if (stop) begin
          w_state_next   = IDLE;
          w_tick_next    = '0;
          w_div_rst_next = 1'b1;
        end else if (!auto_mode) begin
          w_state_next = PLAY_MAN;
          w_tick_next  = '0;
        end else if (w_terminal) begin
          // 3-bit arithmetic gives the 7->0 and 0->7 wrap for free.
          w_tick_next    = '0;
          w_note_next    = direction ? (r_note - 3'd1) : (r_note + 3'd1);
          w_step_next    = 1'b1;
          w_div_rst_next = 1'b1;
        end else begin
          w_tick_next = r_tick + 32'd1;
        end
      end

      default: begin
        w_state_next   = IDLE;
        w_tick_next    = '0;
        w_div_rst_next = 1'b1;
      end
    endcase
  end

  // State register and tick counter.
  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
    end
  end

  // Registered outputs; note index and its terminal count move on the same edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_note      <= 3'd0;
      r_count_end <= NOTE_TABLE[0];
      r_div_rst   <= 1'b1;
      r_step      <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_note      <= w_note_next;
      r_count_end <= NOTE_TABLE[w_note_next];
      r_div_rst   <= w_div_rst_next;
      r_step      <= w_step_next;
      r_playing   <= (w_state_next != IDLE);
    end
  end

  assign count_end     = r_count_end;
  assign divider_reset = r_div_rst;
  assign note_index    = r_note;
  assign step_pulse    = r_step;
  assign playing       = r_playing;

endmodule
